// File: rtl/vec_pkg.sv
// Shared types and constants for the vector CPU memory stage.
// Holds the lane geometry, the lane-vector type and the sequencer state encoding.
package vec_pkg;

   localparam int LANES = 6;
   localparam int N     = 8;
   localparam int IDXW  = 3;

   typedef logic [LANES-1:0][N-1:0] lane_vec_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } mem_state_t;

   // Index of the final lane touched: all lanes for vector ops, lane 0 for scalar ops.
   function automatic logic [IDXW-1:0] last_lane(input logic vec);
      return vec ? IDXW'(LANES - 1) : {IDXW{1'b0}};
   endfunction

endpackage

// File: rtl/vec_mem_lanes.sv
// Memory-stage sequencer: serialises 6-lane vector or scalar loads/stores onto a
// byte-wide synchronous RAM, stalling the pipeline and assembling the load vector.
module vec_mem_lanes #(
   parameter int N     = 8,
   parameter int LANES = 6,
   parameter int AW    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       MemReqM,
   input  logic                       MemWriteM,
   input  logic                       VecM,
   input  logic [AW-1:0]              AddrM,
   input  logic [LANES-1:0][N-1:0]    WriteDataM,
   output logic                       StallM,
   output logic                       DoneM,
   output logic [LANES-1:0][N-1:0]    ReadDataM,
   output logic [AW-1:0]              MemAddr,
   output logic [N-1:0]               MemWData,
   output logic                       MemWE,
   output logic                       MemRE,
   input  logic [N-1:0]               MemRData
);
   import vec_pkg::*;

   mem_state_t                 state_q, state_d;
   logic [IDXW-1:0]            idx_q, idx_d;
   logic [AW-1:0]              base_q;
   logic [LANES-1:0][N-1:0]    wdata_q;
   logic [LANES-1:0][N-1:0]    rdata_q;
   logic                       vec_q;
   logic [IDXW-1:0]            last_s;
   logic                       at_last_s;
   logic                       accept_s;

   assign last_s    = last_lane(vec_q);
   assign at_last_s = (idx_q == last_s);
   assign accept_s  = (state_q == IDLE) && MemReqM;

   // Next-state decode; DONE ignores MemReqM because it still belongs to the finished op.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (MemReqM) begin
               state_d = MemWriteM ? WRITE : READ;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (at_last_s) begin
               state_d = DONE;
            end else begin
               state_d = WRITE;
            end
         end
         READ: begin
            if (at_last_s) begin
               state_d = DRAIN;
            end else begin
               state_d = READ;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      idx_d = idx_q;
      if (accept_s) begin
         idx_d = {IDXW{1'b0}};
      end else if (((state_q == WRITE) || (state_q == READ)) && !at_last_s) begin
         idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
      end else begin
         idx_d = idx_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= {IDXW{1'b0}};
      end else begin
         idx_q <= idx_d;
      end
   end

   // Request operands are captured once; the M-stage inputs are free to change afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= {AW{1'b0}};
         wdata_q <= '0;
         vec_q   <= 1'b0;
      end else if (accept_s) begin
         base_q  <= AddrM;
         wdata_q <= WriteDataM;
         vec_q   <= VecM;
      end
   end

   // RAM data lags MemRE by one cycle, so READ fills lane idx-1 and DRAIN fills the last lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         if (accept_s && !MemWriteM && !VecM) begin
            rdata_q[LANES-1:1] <= '0;
         end
         if ((state_q == READ) && (idx_q != {IDXW{1'b0}})) begin
            rdata_q[idx_q - {{(IDXW-1){1'b0}}, 1'b1}] <= MemRData;
         end
         if (state_q == DRAIN) begin
            rdata_q[last_s] <= MemRData;
         end
      end
   end

   // Memory port decodes purely from registered state; address wraps modulo 2^AW.
   always_comb begin
      MemWE    = 1'b0;
      MemRE    = 1'b0;
      MemAddr  = {AW{1'b0}};
      MemWData = {N{1'b0}};
      case (state_q)
         WRITE: begin
            MemWE    = 1'b1;
            MemAddr  = base_q + AW'(idx_q);
            MemWData = wdata_q[idx_q];
         end
         READ: begin
            MemRE    = 1'b1;
            MemAddr  = base_q + AW'(idx_q);
         end
         default: begin
            MemWE    = 1'b0;
            MemRE    = 1'b0;
         end
      endcase
   end

   assign StallM    = rst_n & (accept_s | (state_q == WRITE) | (state_q == READ) |
                               (state_q == DRAIN));
   assign DoneM     = (state_q == DONE);
   assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_vec_mem_lanes.sv
// Scoreboard bench for vec_mem_lanes: a driver predicts every memory beat, stall
// window and completion, and a negedge monitor compares them against the DUT.
module tb_vec_mem_lanes;
   import vec_pkg::*;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [7:0]  data;
   } mev_t;

   typedef struct {
      int          cyc;
      lane_vec_t   rd;
   } dev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemReqM, MemWriteM, VecM;
   logic [15:0] AddrM;
   lane_vec_t   WriteDataM;
   logic        StallM, DoneM;
   lane_vec_t   ReadDataM;
   logic [15:0] MemAddr;
   logic [7:0]  MemWData;
   logic        MemWE, MemRE;
   logic [7:0]  MemRData;

   logic [7:0]  ram [0:65535];
   logic [7:0]  model_mem [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;

   mev_t        wq[$];
   mev_t        rq[$];
   dev_t        dq[$];
   lane_vec_t   last_rd;
   int          stall_lo = 1;
   int          stall_hi = 0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   vec_mem_lanes dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemReqM    (MemReqM),
      .MemWriteM  (MemWriteM),
      .VecM       (VecM),
      .AddrM      (AddrM),
      .WriteDataM (WriteDataM),
      .StallM     (StallM),
      .DoneM      (DoneM),
      .ReadDataM  (ReadDataM),
      .MemAddr    (MemAddr),
      .MemWData   (MemWData),
      .MemWE      (MemWE),
      .MemRE      (MemRE),
      .MemRData   (MemRData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency byte RAM with a preload port used only while the DUT is idle.
   always @(posedge clk) begin
      if (MemWE) begin
         ram[MemAddr] <= MemWData;
      end else if (pre_we) begin
         ram[pre_addr] <= pre_data;
      end
      if (MemRE) begin
         MemRData <= ram[MemAddr];
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      mev_t e;
      dev_t d;
      check_val("stall", {63'd0, StallM},
                {63'd0, (rst_n === 1'b1) && (cyc >= stall_lo) && (cyc <= stall_hi)});
      if (MemWE === 1'b1) begin
         if (wq.size() == 0) begin
            check_val("we_unexpected", 64'd1, 64'd0);
         end else begin
            e = wq.pop_front();
            check_val("we_cyc", 64'(cyc), 64'(e.cyc));
            check_val("we_addr", {48'd0, MemAddr}, {48'd0, e.addr});
            check_val("we_data", {56'd0, MemWData}, {56'd0, e.data});
         end
      end
      if (MemRE === 1'b1) begin
         if (rq.size() == 0) begin
            check_val("re_unexpected", 64'd1, 64'd0);
         end else begin
            e = rq.pop_front();
            check_val("re_cyc", 64'(cyc), 64'(e.cyc));
            check_val("re_addr", {48'd0, MemAddr}, {48'd0, e.addr});
         end
      end
      if ((MemWE !== 1'b1) && (MemRE !== 1'b1)) begin
         check_val("idle_addr", {48'd0, MemAddr}, 64'd0);
         check_val("idle_wdata", {56'd0, MemWData}, 64'd0);
      end
      if (DoneM === 1'b1) begin
         if (dq.size() == 0) begin
            check_val("done_unexpected", 64'd1, 64'd0);
         end else begin
            d = dq.pop_front();
            check_val("done_cyc", 64'(cyc), 64'(d.cyc));
            check_val("rdata", {16'd0, ReadDataM}, {16'd0, d.rd});
         end
      end
   end

   task automatic check_quiet(input string tag);
      check_val({tag, "_we"}, {63'd0, MemWE}, 64'd0);
      check_val({tag, "_re"}, {63'd0, MemRE}, 64'd0);
      check_val({tag, "_addr"}, {48'd0, MemAddr}, 64'd0);
      check_val({tag, "_wdata"}, {56'd0, MemWData}, 64'd0);
      check_val({tag, "_stall"}, {63'd0, StallM}, 64'd0);
      check_val({tag, "_done"}, {63'd0, DoneM}, 64'd0);
      check_val({tag, "_rdata"}, {16'd0, ReadDataM}, 64'd0);
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the DONE cycle,
   // or, when abort_at>=0, after resetting the DUT during WRITE lane abort_at.
   task automatic issue(input logic wr, input logic vec, input logic [15:0] addr,
                        input lane_vec_t data, input int abort_at);
      int        k;
      int        c0;
      int        dc;
      lane_vec_t rd;
      mev_t      e;
      dev_t      d;
      k  = vec ? LANES : 1;
      c0 = cyc;
      MemReqM    = 1'b1;
      MemWriteM  = wr;
      VecM       = vec;
      AddrM      = addr;
      WriteDataM = data;
      rd = wr ? last_rd : '0;
      for (int i = 0; i < k; i++) begin
         e.cyc  = c0 + 1 + i;
         e.addr = addr + 16'(i);
         e.data = data[i];
         if (wr) begin
            wq.push_back(e);
            if ((abort_at < 0) || (i < abort_at)) model_mem[e.addr] = data[i];
         end else begin
            rq.push_back(e);
            rd[i] = model_mem[e.addr];
         end
      end
      dc = wr ? (c0 + k + 1) : (c0 + k + 2);
      d.cyc = dc;
      d.rd  = rd;
      dq.push_back(d);
      last_rd  = rd;
      stall_lo = c0;
      stall_hi = dc - 1;
      if (abort_at >= 0) begin
         repeat (abort_at + 1) @(posedge clk);
         #2;
         rst_n   = 1'b0;
         MemReqM = 1'b0;
         #1;
         check_quiet("midrst");
         wq.delete();
         rq.delete();
         dq.delete();
         stall_lo = 1;
         stall_hi = 0;
         last_rd  = '0;
         @(negedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk);
         #1;
      end else begin
         for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (DoneM) break;
            AddrM      = 16'($urandom);
            WriteDataM = 48'({$urandom, $urandom});
            VecM       = 1'($urandom);
            MemWriteM  = 1'($urandom);
         end
         check_val("done_seen", {63'd0, DoneM}, 64'd1);
      end
   endtask

   task automatic idle(input int n);
      MemReqM = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      @(posedge clk);
      #1;
      pre_we   = 1'b1;
      pre_addr = a;
      pre_data = v;
      model_mem[a] = v;
   endtask

   initial begin
      rst_n      = 1'b0;
      MemReqM    = 1'b0;
      MemWriteM  = 1'b0;
      VecM       = 1'b0;
      AddrM      = 16'h0000;
      WriteDataM = '0;
      pre_we     = 1'b0;
      pre_addr   = 16'h0000;
      pre_data   = 8'h00;
      last_rd    = '0;
      for (int i = 0; i < LANES; i++) preload(16'h0020 + 16'(i), 8'hA0 + 8'(i));
      preload(16'h0030, 8'h7F);
      @(posedge clk);
      #1;
      pre_we = 1'b0;
      check_quiet("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b1, 1'b1, 16'h0010, {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, -1);
      idle(2);
      issue(1'b0, 1'b1, 16'h0020, '0, -1);
      idle(2);
      issue(1'b0, 1'b0, 16'h0030, '0, -1);
      idle(2);
      issue(1'b1, 1'b1, 16'hFFFD, {8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1}, -1);
      idle(2);
      issue(1'b0, 1'b1, 16'hFFFD, '0, -1);
      idle(2);
      issue(1'b1, 1'b0, 16'h0040, {40'd0, 8'h5A}, -1);
      idle(2);
      issue(1'b1, 1'b1, 16'h0050, {8'hB6, 8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1}, 3);
      issue(1'b0, 1'b1, 16'h0010, '0, -1);
      idle(2);
      issue(1'b0, 1'b0, 16'h0052, '0, -1);
      idle(2);
      issue(1'b1, 1'b1, 16'h0060, {8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1}, -1);
      @(posedge clk);
      #1;
      issue(1'b0, 1'b1, 16'h0060, '0, -1);
      idle(4);

      check_val("wq_drained", 64'(wq.size()), 64'd0);
      check_val("rq_drained", 64'(rq.size()), 64'd0);
      check_val("dq_drained", 64'(dq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
